// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the activation stack sequencer: FSM state encoding,
// default geometry and the stack word width derivation.
package stack_ctrl_pkg;

    localparam int DEF_NEURON_NUM       = 6;
    localparam int DEF_ACTIVATION_WIDTH = 8;
    localparam int DEF_STACK_ADDR_WIDTH = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUSH    = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_EMIT    = 3'd4,
        ST_DONE    = 3'd5
    } ctrl_state_t;

    // One stack word holds a whole layer vector.
    function automatic int stack_width(input int neuron_num, input int activation_width);
        return neuron_num * activation_width;
    endfunction

endpackage

// File: rtl/pair_join.sv
// Two independent valid/ready capture slots joined into one valid/ready output;
// the slots are opened by a one-cycle arm pulse and closed by their own capture.
module pair_join #(
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic [WIDTH-1:0] lower_data,
    input  logic             lower_valid,
    output logic             lower_ready,
    input  logic [WIDTH-1:0] higher_data,
    input  logic             higher_valid,
    output logic             higher_ready,
    output logic [WIDTH-1:0] out_lower,
    output logic [WIDTH-1:0] out_higher,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             joined
);

    logic lower_full;
    logic higher_full;
    logic lower_fire;
    logic higher_fire;
    logic out_fire;

    assign lower_fire  = lower_valid && lower_ready;
    assign higher_fire = higher_valid && higher_ready;
    assign out_fire    = out_valid && out_ready;

    // High in the cycle the second of the two slots is filled.
    assign joined = !out_valid && (lower_full || lower_fire) && (higher_full || higher_fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lower_ready  <= 1'b0;
            higher_ready <= 1'b0;
            lower_full   <= 1'b0;
            higher_full  <= 1'b0;
            out_lower    <= '0;
            out_higher   <= '0;
            out_valid    <= 1'b0;
        end else begin
            if (arm) begin
                lower_ready  <= 1'b1;
                higher_ready <= 1'b1;
            end
            if (lower_fire) begin
                out_lower   <= lower_data;
                lower_full  <= 1'b1;
                lower_ready <= 1'b0;
            end
            if (higher_fire) begin
                out_higher   <= higher_data;
                higher_full  <= 1'b1;
                higher_ready <= 1'b0;
            end
            if (joined) begin
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid   <= 1'b0;
                lower_full  <= 1'b0;
                higher_full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/activation_stack_ctrl.sv
// Activation stack sequencer: pushes L+1 forward vectors, then reads adjacent
// pairs top-down for backprop. Optional start bound check: ACTIVATION_STACK_CTRL_BOUND_CHECK_EN.
module activation_stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int NEURON_NUM       = DEF_NEURON_NUM,
    parameter int ACTIVATION_WIDTH = DEF_ACTIVATION_WIDTH,
    parameter int STACK_ADDR_WIDTH = DEF_STACK_ADDR_WIDTH,
    localparam int STACK_WIDTH     = stack_width(NEURON_NUM, ACTIVATION_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [STACK_ADDR_WIDTH-1:0] num_layers,
    output logic                        busy,
    output logic                        done,
    input  logic [STACK_WIDTH-1:0]      fwd_data,
    input  logic                        fwd_valid,
    output logic                        fwd_ready,
    output logic [STACK_WIDTH-1:0]      stack_input_data,
    output logic                        stack_input_data_valid,
    input  logic                        stack_input_data_ready,
    output logic [STACK_ADDR_WIDTH-1:0] stack_input_addr,
    output logic                        stack_input_addr_valid,
    input  logic                        stack_input_addr_ready,
    output logic [STACK_ADDR_WIDTH-1:0] stack_output_addr,
    output logic                        stack_output_addr_valid,
    input  logic                        stack_output_addr_ready,
    input  logic [STACK_WIDTH-1:0]      stack_output_data_lower,
    input  logic                        stack_output_data_lower_valid,
    output logic                        stack_output_data_lower_ready,
    input  logic [STACK_WIDTH-1:0]      stack_output_data_higher,
    input  logic                        stack_output_data_higher_valid,
    output logic                        stack_output_data_higher_ready,
    output logic [STACK_WIDTH-1:0]      bwd_lower,
    output logic [STACK_WIDTH-1:0]      bwd_higher,
    output logic [STACK_ADDR_WIDTH-1:0] bwd_layer,
    output logic                        bwd_valid,
    input  logic                        bwd_ready
`ifdef ACTIVATION_STACK_CTRL_BOUND_CHECK_EN
    ,
    output logic                        error
`endif
);

    localparam logic [STACK_ADDR_WIDTH-1:0] ADDR_ONE = STACK_ADDR_WIDTH'(1);

    ctrl_state_t                 state;
    logic [STACK_ADDR_WIDTH-1:0] num_layers_q;
    logic [STACK_ADDR_WIDTH-1:0] wr_ptr;
    logic [STACK_ADDR_WIDTH-1:0] rd_ptr;

    logic fwd_fire;
    logic write_pending;
    logic write_last;
    logic rd_addr_fire;
    logic bwd_fire;
    logic pair_joined;
    logic start_accept;

    assign fwd_fire      = fwd_valid && fwd_ready;
    assign write_pending = stack_input_data_valid || stack_input_addr_valid;
    // The write completes on the edge where the last outstanding valid is accepted.
    assign write_last    = write_pending
                         && !(stack_input_data_valid && !stack_input_data_ready)
                         && !(stack_input_addr_valid && !stack_input_addr_ready);
    assign rd_addr_fire  = stack_output_addr_valid && stack_output_addr_ready;
    assign bwd_fire      = bwd_valid && bwd_ready;

`ifdef ACTIVATION_STACK_CTRL_BOUND_CHECK_EN
    localparam logic [STACK_ADDR_WIDTH-1:0] ADDR_MAX = '1;
    logic start_reject;
    assign start_accept = start && (num_layers != '0) && (num_layers != ADDR_MAX);
    assign start_reject = start && !start_accept;
`else
    assign start_accept = start;
`endif

    // Sequencer: every stack-facing valid and address is a register driven here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                   <= ST_IDLE;
            num_layers_q            <= '0;
            wr_ptr                  <= '0;
            rd_ptr                  <= '0;
            busy                    <= 1'b0;
            done                    <= 1'b0;
            fwd_ready               <= 1'b0;
            stack_input_data        <= '0;
            stack_input_data_valid  <= 1'b0;
            stack_input_addr        <= '0;
            stack_input_addr_valid  <= 1'b0;
            stack_output_addr       <= '0;
            stack_output_addr_valid <= 1'b0;
            bwd_layer               <= '0;
`ifdef ACTIVATION_STACK_CTRL_BOUND_CHECK_EN
            error                   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef ACTIVATION_STACK_CTRL_BOUND_CHECK_EN
            error <= start_reject && (state == ST_IDLE);
`endif
            case (state)
                ST_IDLE: begin
                    if (start_accept) begin
                        num_layers_q <= num_layers;
                        wr_ptr       <= '0;
                        rd_ptr       <= num_layers - ADDR_ONE;
                        fwd_ready    <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ST_PUSH;
                    end
                end

                ST_PUSH: begin
                    if (fwd_fire) begin
                        fwd_ready              <= 1'b0;
                        stack_input_data       <= fwd_data;
                        stack_input_addr       <= wr_ptr;
                        stack_input_data_valid <= 1'b1;
                        stack_input_addr_valid <= 1'b1;
                    end else if (write_pending) begin
                        if (stack_input_data_ready) begin
                            stack_input_data_valid <= 1'b0;
                        end
                        if (stack_input_addr_ready) begin
                            stack_input_addr_valid <= 1'b0;
                        end
                        if (write_last) begin
                            if (wr_ptr != num_layers_q) begin
                                wr_ptr    <= wr_ptr + ADDR_ONE;
                                fwd_ready <= 1'b1;
                            end else if (num_layers_q == '0) begin
                                // A single-vector pass has no pairs to read back.
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                stack_output_addr       <= rd_ptr;
                                stack_output_addr_valid <= 1'b1;
                                state                   <= ST_RD_ADDR;
                            end
                        end
                    end
                end

                ST_RD_ADDR: begin
                    if (rd_addr_fire) begin
                        stack_output_addr_valid <= 1'b0;
                        bwd_layer               <= rd_ptr;
                        state                   <= ST_RD_WAIT;
                    end
                end

                ST_RD_WAIT: begin
                    if (pair_joined) begin
                        state <= ST_EMIT;
                    end
                end

                ST_EMIT: begin
                    if (bwd_fire) begin
                        if (rd_ptr == '0) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            rd_ptr                  <= rd_ptr - ADDR_ONE;
                            stack_output_addr       <= rd_ptr - ADDR_ONE;
                            stack_output_addr_valid <= 1'b1;
                            state                   <= ST_RD_ADDR;
                        end
                    end
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pair capture for the read-back path; its output register is the bwd channel.
    pair_join #(
        .WIDTH (STACK_WIDTH)
    ) u_pair_join (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (rd_addr_fire),
        .lower_data   (stack_output_data_lower),
        .lower_valid  (stack_output_data_lower_valid),
        .lower_ready  (stack_output_data_lower_ready),
        .higher_data  (stack_output_data_higher),
        .higher_valid (stack_output_data_higher_valid),
        .higher_ready (stack_output_data_higher_ready),
        .out_lower    (bwd_lower),
        .out_higher   (bwd_higher),
        .out_valid    (bwd_valid),
        .out_ready    (bwd_ready),
        .joined       (pair_joined)
    );

endmodule

// File: tb/tb_activation_stack_ctrl.sv
// Scoreboard bench for activation_stack_ctrl: a stack model answers reads,
// expected writes/reads/pairs are queued at stimulus time and checked by a monitor.
module tb_activation_stack_ctrl;

    localparam int W  = 48;
    localparam int AW = 10;

    typedef struct {
        int           addr;
        logic [W-1:0] data;
    } wr_exp_t;

    typedef struct {
        int           layer;
        logic [W-1:0] lower;
        logic [W-1:0] higher;
    } bwd_exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] num_layers;
    logic          busy;
    logic          done;
    logic [W-1:0]  fwd_data;
    logic          fwd_valid;
    logic          fwd_ready;
    logic [W-1:0]  sid;
    logic          sid_valid;
    logic          sid_ready;
    logic [AW-1:0] sia;
    logic          sia_valid;
    logic          sia_ready;
    logic [AW-1:0] soa;
    logic          soa_valid;
    logic          soa_ready;
    logic [W-1:0]  lo_data;
    logic          lo_valid;
    logic          lo_ready;
    logic [W-1:0]  hi_data;
    logic          hi_valid;
    logic          hi_ready;
    logic [W-1:0]  bwd_lower;
    logic [W-1:0]  bwd_higher;
    logic [AW-1:0] bwd_layer;
    logic          bwd_valid;
    logic          bwd_ready;
`ifdef ACTIVATION_STACK_CTRL_BOUND_CHECK_EN
    logic          error;
`endif

    activation_stack_ctrl dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .start                          (start),
        .num_layers                     (num_layers),
        .busy                           (busy),
        .done                           (done),
        .fwd_data                       (fwd_data),
        .fwd_valid                      (fwd_valid),
        .fwd_ready                      (fwd_ready),
        .stack_input_data               (sid),
        .stack_input_data_valid         (sid_valid),
        .stack_input_data_ready         (sid_ready),
        .stack_input_addr               (sia),
        .stack_input_addr_valid         (sia_valid),
        .stack_input_addr_ready         (sia_ready),
        .stack_output_addr              (soa),
        .stack_output_addr_valid        (soa_valid),
        .stack_output_addr_ready        (soa_ready),
        .stack_output_data_lower        (lo_data),
        .stack_output_data_lower_valid  (lo_valid),
        .stack_output_data_lower_ready  (lo_ready),
        .stack_output_data_higher       (hi_data),
        .stack_output_data_higher_valid (hi_valid),
        .stack_output_data_higher_ready (hi_ready),
        .bwd_lower                      (bwd_lower),
        .bwd_higher                     (bwd_higher),
        .bwd_layer                      (bwd_layer),
        .bwd_valid                      (bwd_valid),
        .bwd_ready                      (bwd_ready)
`ifdef ACTIVATION_STACK_CTRL_BOUND_CHECK_EN
        ,
        .error                          (error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard queues and the behavioural stack memory.
    wr_exp_t      exp_wr[$];
    int           exp_rd[$];
    bwd_exp_t     exp_bwd[$];
    logic [W-1:0] fwd_src[$];
    logic [W-1:0] stim_vecs[$];
    logic [W-1:0] mem [0:1024];
    int           lo_q[$];
    int           hi_q[$];

    int rand_bp    = 0;
    int addr_delay = 0;
    int hi_lead    = 0;
    int bwd_stall  = 0;

    bit fwd_fired, lo_fired, hi_fired, wa_fired, bwd_fired;
    bit wd_got, wa_got, lo_got, hi_got, expect_bwd_next, hold_armed;
    logic [W-1:0]  wd_val;
    int            wa_val;
    logic [127:0]  held;
    int lo_wait, hi_wait, addr_wait, stall_cnt;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportMissing(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got an unexpected or missing event", name);
    endtask

    // Reference model: L+1 writes at 0..L, then pairs (k, v[k], v[k+1]) for k = L-1 down to 0.
    task automatic applyStimulus(input int l);
        wr_exp_t  w;
        bwd_exp_t b;
        for (int i = 0; i <= l; i++) begin
            w.addr = i;
            w.data = stim_vecs[i];
            exp_wr.push_back(w);
            fwd_src.push_back(stim_vecs[i]);
        end
        for (int k = l - 1; k >= 0; k--) begin
            exp_rd.push_back(k);
            b.layer  = k;
            b.lower  = stim_vecs[k];
            b.higher = stim_vecs[k + 1];
            exp_bwd.push_back(b);
        end
        @(posedge clk);
        #1;
        start      = 1'b1;
        num_layers = AW'(l);
        @(posedge clk);
        #1;
        start      = 1'b0;
        num_layers = AW'($urandom);
        checkOutput("busy_after_start", busy, 1);
        checkOutput("fwd_ready_after_start", fwd_ready, 1);
    endtask

    task automatic randomVecs(input int l);
        logic [63:0] r;
        stim_vecs.delete();
        for (int i = 0; i <= l; i++) begin
            r = {$urandom, $urandom};
            stim_vecs.push_back(r[W-1:0]);
        end
    endtask

    task automatic flushAll();
        exp_wr.delete();
        exp_rd.delete();
        exp_bwd.delete();
        fwd_src.delete();
        lo_q.delete();
        hi_q.delete();
        fwd_valid = 1'b0;
        lo_valid  = 1'b0;
        hi_valid  = 1'b0;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n = 1'b0;
        flushAll();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic waitDone(input int budget, input int poke_cycle);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
            start = (!seen && i == poke_cycle);
            if (start) num_layers = AW'(5);
        end
        start = 1'b0;
        if (!seen) begin
            reportMissing("done_timeout");
            resetDut();
        end else begin
            checkOutput("busy_in_done", busy, 1);
            checkOutput("pairs_left", exp_bwd.size(), 0);
            checkOutput("writes_left", exp_wr.size(), 0);
            checkOutput("reads_left", exp_rd.size(), 0);
            @(negedge clk);
            checkOutput("done_one_cycle", done, 0);
            checkOutput("busy_falls", busy, 0);
        end
    endtask

    // Stimulus driver: responds to the handshakes the monitor saw on the previous falling edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                fwd_valid = 1'b0;
                lo_valid  = 1'b0;
                hi_valid  = 1'b0;
                lo_q.delete();
                hi_q.delete();
                stall_cnt = 0;
                addr_wait = 0;
            end else begin
                if (fwd_fired) begin
                    void'(fwd_src.pop_front());
                    fwd_valid = 1'b0;
                end
                if (!fwd_valid && fwd_src.size() > 0 && (rand_bp == 0 || $urandom_range(1, 0) == 1)) begin
                    fwd_valid = 1'b1;
                    fwd_data  = fwd_src[0];
                end
                sid_ready = (rand_bp == 0) ? 1'b1 : 1'($urandom_range(1, 0));
                if (wa_fired) addr_wait = 0;
                if (sia_valid && addr_wait < addr_delay) begin
                    sia_ready = 1'b0;
                    addr_wait++;
                end else begin
                    sia_ready = (rand_bp == 0) ? 1'b1 : 1'($urandom_range(1, 0));
                end
                soa_ready = (rand_bp == 0) ? 1'b1 : 1'($urandom_range(1, 0));
                if (lo_fired) begin
                    lo_valid = 1'b0;
                    void'(lo_q.pop_front());
                end
                if (!lo_valid && lo_q.size() > 0) begin
                    if (lo_wait > 0) lo_wait--;
                    else begin
                        lo_valid = 1'b1;
                        lo_data  = mem[lo_q[0]];
                    end
                end
                if (hi_fired) begin
                    hi_valid = 1'b0;
                    void'(hi_q.pop_front());
                end
                if (!hi_valid && hi_q.size() > 0) begin
                    if (hi_wait > 0) hi_wait--;
                    else begin
                        hi_valid = 1'b1;
                        hi_data  = mem[hi_q[0] + 1];
                    end
                end
                if (bwd_fired) stall_cnt = 0;
                if (bwd_valid && stall_cnt < bwd_stall) begin
                    bwd_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    bwd_ready = (rand_bp == 0) ? 1'b1 : 1'($urandom_range(1, 0));
                end
            end
            fwd_fired = 0;
            lo_fired  = 0;
            hi_fired  = 0;
            wa_fired  = 0;
            bwd_fired = 0;
        end
    end

    // Monitor: observes handshakes and compares against the scoreboard queues.
    initial begin
        wr_exp_t  w;
        bwd_exp_t b;
        int       a;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wd_got = 0; wa_got = 0; lo_got = 0; hi_got = 0;
                expect_bwd_next = 0; hold_armed = 0;
            end else begin
                if (expect_bwd_next) begin
                    checkOutput("bwd_valid_latency", bwd_valid, 1);
                    expect_bwd_next = 0;
                end
                if (hold_armed)
                    checkOutput("bwd_hold", {bwd_valid, bwd_layer, bwd_lower, bwd_higher}, held);
                hold_armed = bwd_valid && !bwd_ready;
                held = {1'b1, bwd_layer, bwd_lower, bwd_higher};
                if (fwd_ready)
                    checkOutput("fwd_ready_while_pending", sid_valid || sia_valid, 0);
                if (bwd_valid)
                    checkOutput("rd_addr_during_emit", soa_valid, 0);

                if (fwd_valid && fwd_ready) fwd_fired = 1;
                if (sid_valid && sid_ready) begin
                    wd_got = 1;
                    wd_val = sid;
                end
                if (sia_valid && sia_ready) begin
                    wa_got   = 1;
                    wa_val   = int'(sia);
                    wa_fired = 1;
                end
                if (wd_got && wa_got) begin
                    if (exp_wr.size() == 0) reportMissing("unexpected_write");
                    else begin
                        w = exp_wr.pop_front();
                        checkOutput("write_addr", wa_val, w.addr);
                        checkOutput("write_data", wd_val, w.data);
                    end
                    mem[wa_val] = wd_val;
                    wd_got = 0;
                    wa_got = 0;
                end
                if (soa_valid && soa_ready) begin
                    a = int'(soa);
                    if (exp_rd.size() == 0) reportMissing("unexpected_read");
                    else checkOutput("read_addr", a, exp_rd.pop_front());
                    lo_q.push_back(a);
                    hi_q.push_back(a);
                    lo_wait = (rand_bp != 0) ? int'($urandom_range(2, 0)) : ((hi_lead != 0) ? 2 : 0);
                    hi_wait = (rand_bp != 0) ? int'($urandom_range(2, 0)) : 0;
                end
                if (lo_valid && lo_ready) begin
                    lo_fired = 1;
                    lo_got   = 1;
                end
                if (hi_valid && hi_ready) begin
                    hi_fired = 1;
                    hi_got   = 1;
                end
                if ((lo_fired || hi_fired) && lo_got && hi_got) begin
                    checkOutput("bwd_valid_early", bwd_valid, 0);
                    expect_bwd_next = 1;
                end
                if (bwd_valid && bwd_ready) begin
                    bwd_fired = 1;
                    lo_got    = 0;
                    hi_got    = 0;
                    if (exp_bwd.size() == 0) reportMissing("unexpected_pair");
                    else begin
                        b = exp_bwd.pop_front();
                        checkOutput("bwd_layer", bwd_layer, b.layer);
                        checkOutput("bwd_lower", bwd_lower, b.lower);
                        checkOutput("bwd_higher", bwd_higher, b.higher);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit armed;
        rst_n = 1'b0;
        start = 1'b0;
        num_layers = '0;
        fwd_data = '0;
        fwd_valid = 1'b0;
        sid_ready = 1'b1;
        sia_ready = 1'b1;
        soa_ready = 1'b1;
        lo_data = '0;
        lo_valid = 1'b0;
        hi_data = '0;
        hi_valid = 1'b0;
        bwd_ready = 1'b1;
        for (int i = 0; i <= 1024; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_fwd_ready", fwd_ready, 0);
        checkOutput("reset_wr_valids", {sid_valid, sia_valid, soa_valid}, 0);
        checkOutput("reset_rd_readies", {lo_ready, hi_ready, bwd_valid}, 0);
        checkOutput("reset_data", {sid, sia, soa, bwd_layer}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed pass L=3");
        stim_vecs = '{48'd100, 48'd200, 48'd300, 48'd400};
        applyStimulus(3);
        waitDone(2000, -1);

        $display("[TB] delayed write address ready");
        addr_delay = 3;
        randomVecs(2);
        applyStimulus(2);
        waitDone(2000, -1);
        addr_delay = 0;

        $display("[TB] higher port leads lower");
        hi_lead = 1;
        randomVecs(2);
        applyStimulus(2);
        waitDone(2000, -1);

        $display("[TB] bwd backpressure with ignored start");
        hi_lead = 0;
        bwd_stall = 5;
        randomVecs(2);
        applyStimulus(2);
        waitDone(2000, 20);
        bwd_stall = 0;

        $display("[TB] reset during read wait");
        hi_lead = 1;
        randomVecs(3);
        applyStimulus(3);
        armed = 0;
        for (int i = 0; i < 500 && !armed; i++) begin
            @(negedge clk);
            if (lo_ready) armed = 1;
        end
        if (!armed) reportMissing("rd_wait_timeout");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy_done", {busy, done}, 0);
        checkOutput("abort_valids", {fwd_ready, sid_valid, sia_valid, soa_valid, bwd_valid}, 0);
        checkOutput("abort_readies", {lo_ready, hi_ready}, 0);
        checkOutput("abort_addrs", {soa, sia, bwd_layer}, 0);
        flushAll();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        hi_lead = 0;
        randomVecs(2);
        applyStimulus(2);
        waitDone(2000, -1);

        $display("[TB] randomized passes with backpressure");
        rand_bp = 1;
        for (int t = 0; t < 8; t++) begin
            int l;
            l = int'($urandom_range(6, 1));
            randomVecs(l);
            applyStimulus(l);
            waitDone(4000, int'($urandom_range(40, 5)));
        end
        rand_bp = 0;

`ifdef ACTIVATION_STACK_CTRL_BOUND_CHECK_EN
        $display("[TB] out-of-range starts rejected");
        for (int t = 0; t < 2; t++) begin
            @(posedge clk);
            #1;
            start = 1'b1;
            num_layers = (t == 0) ? AW'(0) : AW'(1023);
            @(posedge clk);
            #1;
            start = 1'b0;
            checkOutput("reject_error_pulse", error, 1);
            checkOutput("reject_busy", busy, 0);
            @(posedge clk);
            #1;
            checkOutput("reject_error_clear", error, 0);
            checkOutput("reject_stay_idle", {busy, fwd_ready}, 0);
        end
`else
        $display("[TB] single-vector pass L=0");
        randomVecs(0);
        applyStimulus(0);
        waitDone(2000, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
